// File: rtl/reg_file_mp.sv
// reg_file_mp: flop-array register file with NRD registered read ports and one write port (clk, rst, rd_en_n/rd_addr -> rd_data/rd_valid, wr_en_n/wr_addr/wr_data); define REG_FILE_MP_BYPASS_EN for write-first reads
module reg_file_mp #(
  parameter int W        = 32,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NRD-1:0]    rd_en_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*W-1:0]  rd_data,
  output logic [NRD-1:0]    rd_valid,
  input  logic            wr_en_n,
  input  logic [AW-1:0]   wr_addr,
  input  logic [W-1:0]    wr_data
);
`ifdef REG_FILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [W-1:0] r_mem [DEPTH];
  logic         w_we;
  logic [W-1:0] w_rd [NRD];
  assign w_we = !wr_en_n && (32'(wr_addr) < DEPTH) && !(ZERO_REG != 0 && wr_addr == '0);
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] w_a;
    assign w_a = rd_addr[p*AW +: AW];
    assign w_rd[p] = (32'(w_a) >= DEPTH) ? '1 :
                     (ZERO_REG != 0 && w_a == '0) ? '0 :
                     (BYP && w_we && wr_addr == w_a) ? wr_data : r_mem[w_a];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      rd_data  <= '1;
      rd_valid <= '0;
    end else begin
      if (w_we) r_mem[wr_addr] <= wr_data;
      for (int i = 0; i < NRD; i++) begin
        rd_data[i*W +: W] <= rd_en_n[i] ? '1 : w_rd[i];
        rd_valid[i]       <= !rd_en_n[i];
      end
    end
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file; next-generation operand store for the filter processor datapath.
- Generalises data width, depth and read-port count. Adds synchronous reset, per-port read-valid flags, out-of-range handling and an optional hard-wired zero register.
- Reads and writes occur on the same rising edge.
- Sits between decode (addresses and enables) and the filter ALU (operands); writeback drives the write port.

Parameters:
- W, 32, data word width in bits.
- DEPTH, 16, number of registers (need not be a power of two).
- AW, 4, address width in bits; requirement: 2^AW >= DEPTH.
- NRD, 2, number of independent read ports (1..8).
- ZERO_REG, 0, when 1, register 0 always reads zero and ignores writes.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en_n  in  NRD  per-port read enable, active low; bit p belongs to port p.
- rd_addr  in  NRD*AW  packed read addresses; port p uses bits [p*AW +: AW].
- rd_data  out  NRD*W  packed registered read data; port p uses bits [p*W +: W].
- rd_valid  out  NRD  per-port flag: the data on this port is from a performed read.
- wr_en_n  in  1  write enable, active low.
- wr_addr  in  AW  write address.
- wr_data  in  W  write data.

Behaviour:
- Reset (rst=1 at a rising edge):
  - all DEPTH entries cleared to 0;
  - rd_data for every port set to all-ones;
  - rd_valid set to 0;
  - any write presented in the same cycle is dropped.
- Write: at the rising edge with wr_en_n=0, rst=0 and wr_addr<DEPTH, entry[wr_addr] <= wr_data.
  - wr_addr >= DEPTH: write ignored, no state change.
  - ZERO_REG=1 and wr_addr=0: write ignored.
- Read, port p, latency 1 cycle:
  - rd_en_n[p]=0 at edge N: rd_data[p] holds the entry value from edge N onward and rd_valid[p]=1.
  - rd_en_n[p]=1: rd_data[p] <= all-ones and rd_valid[p] <= 0.
  - Outputs hold until the next edge; there is no hold mode.
- Read of rd_addr >= DEPTH: rd_data <= all-ones, rd_valid <= 1. The read is performed; the address is invalid.
- ZERO_REG=1 and rd_addr=0: rd_data <= 0, rd_valid <= 1.
- Read-during-write to the same address on the same edge: result depends on BYPASS_EN (see Optional Feature).
- Multiple ports may read the same address on the same edge; all receive identical data.
- Ports are fully independent; there are no arbitration or stall conditions.
- Storage is a flop array, DEPTH x W. No memory-macro inference is required, because reset must clear every entry.
- Width rules:
  - rd_data and wr_data are exactly W bits; no sign extension.
  - all-ones means {W{1'b1}}.
- X-safety: any X on rd_en_n or wr_en_n while rst=1 has no effect.

Optional Feature:
- Macro: REG_FILE_MP_BYPASS_EN
- Defined: a read on the same edge as a write to the same valid address returns the new wr_data (write-first). Exception: ZERO_REG=1 with address 0 still returns 0.
- Undefined: the same case returns the pre-write contents (read-first); the new value is visible from the next read onward.
- The storage update is identical in both builds.

Test Plan:
1. Reset then read: rst=1 for 2 cycles, then rd_en_n=0 on both ports with addresses 3 and 15 -> one cycle later rd_data=0x00000000 on both ports, rd_valid=2'b11. During reset rd_data=0xFFFFFFFF and rd_valid=0.
2. Write then read back: write 0xA5A5_0001 to addr 5, then 0x1234_5678 to addr 9; next cycle read port0=5, port1=9 -> 0xA5A5_0001 / 0x1234_5678 one cycle later. Repeat with port0=port1=9 -> both ports return 0x1234_5678.
3. Disabled and out-of-range: rd_en_n=2'b10 with port0 addr=5 -> port1 rd_data=0xFFFFFFFF, rd_valid[1]=0, port0 valid. Run with DEPTH=12: read addr 13 -> 0xFFFFFFFF with valid=1; write addr 13 does not alter any entry (scan all 12 entries).
4. Read-during-write: entry 7 = 0x11; same edge write 0x22 to addr 7 and read addr 7 -> with REG_FILE_MP_BYPASS_EN, 0x22; without it, 0x11, then 0x22 on the next read.
5. ZERO_REG=1: write 0xDEAD_BEEF to addr 0, then read addr 0 in both bypass builds -> 0x00000000 with valid=1. Write to addr 1 behaves normally.
6. Reset mid-operation: write 0x55 to addr 2 on the same edge as rst=1 with a read enabled -> entry 2 stays 0, rd_data=0xFFFFFFFF, rd_valid=0. After release, reading addr 2 returns 0.
